// File: rtl/ppcpu_clk_pkg.sv
// ppcpu_clk_pkg: shared constants and state encoding for the core clock divider
package ppcpu_clk_pkg;
  localparam logic [23:0] CLK_DIV_ADDR = 24'h001001;
  localparam int CLK_DIV_SPLIT_BIT = 15;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {OFF, RUN, SWITCH} state_t;
endpackage

// File: rtl/cw_clk_div.sv
// cw_clk_div: glitch-free core clock divider; ports i_clk/i_rst, u_wb_cyc/u_wb_o_dat/u_wb_ack_clk in, cw_clk/ic_split_clock/o_div_cur/o_cfg_pending out
module cw_clk_div
  import ppcpu_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             u_wb_cyc,
  input  logic [15:0]      u_wb_o_dat,
  input  logic             u_wb_ack_clk,
  output logic             cw_clk,
  output logic             ic_split_clock,
  output logic [CNT_W-1:0] o_div_cur,
  output logic             o_cfg_pending
);
  state_t state;
  logic [CNT_W-1:0] cur_div, pend_div, cnt;
  logic cur_split, pend_split, pending, apply, unused_dat;
  assign unused_dat = ^u_wb_o_dat[14:CNT_W];
  // OFF already has cw_clk low, so it may apply directly without passing through SWITCH
  assign apply = pending && !u_wb_cyc && (state == SWITCH || state == OFF);
  assign ic_split_clock = cur_split;
  assign o_div_cur = cur_div;
  assign o_cfg_pending = pending;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= OFF;
      cur_div <= '0;
      pend_div <= '0;
      cnt <= '0;
      cur_split <= 1'b0;
      pend_split <= 1'b0;
      pending <= 1'b0;
      cw_clk <= 1'b0;
    end else begin
      if (u_wb_ack_clk) begin
        pend_div <= u_wb_o_dat[CNT_W-1:0];
        pend_split <= u_wb_o_dat[CLK_DIV_SPLIT_BIT];
      end
      // a write landing on the apply edge keeps the new values pending
      pending <= u_wb_ack_clk | (pending & ~apply);
      if (apply) begin
        cur_div <= pend_div;
        cur_split <= pend_split;
        cnt <= '0;
        cw_clk <= 1'b0;
        state <= pend_split ? RUN : OFF;
      end else if (state == RUN) begin
        if (cnt == cur_div) begin
          cnt <= '0;
          cw_clk <= ~cw_clk;
          // only a falling boundary may hand over to SWITCH
          if (cw_clk && pending) state <= SWITCH;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
        cw_clk <= 1'b0;
        if (pending) state <= SWITCH;
      end
    end
  end
endmodule

// File: tb/tb_cw_clk_div.sv
// tb_cw_clk_div: directed scoreboard bench for cw_clk_div
module tb_cw_clk_div;
  typedef struct {
    string tag;
    logic cw;
    logic sp;
    logic [7:0] dv;
    logic pd;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, ack = 1'b0;
  logic [15:0] dat = '0;
  logic cw, sp, pd;
  logic [7:0] dv;
  exp_t sb[$];
  int n_assert = 0, n_fail = 0;
  cw_clk_div dut (
    .i_clk(clk),
    .i_rst(rst),
    .u_wb_cyc(cyc),
    .u_wb_o_dat(dat),
    .u_wb_ack_clk(ack),
    .cw_clk(cw),
    .ic_split_clock(sp),
    .o_div_cur(dv),
    .o_cfg_pending(pd)
  );
  always #5 clk = ~clk;
  task automatic step(input string tag, input logic r, a, c, input logic [15:0] d,
                      input logic ecw, esp, input logic [7:0] edv, input logic epd);
    exp_t e;
    rst = r;
    ack = a;
    cyc = c;
    dat = d;
    sb.push_back('{tag, ecw, esp, edv, epd});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_assert++;
    assert ({cw, sp, dv, pd} === {e.cw, e.sp, e.dv, e.pd})
    else begin
      n_fail++;
      $error("FAIL %s: got cw=%b split=%b div=%0d pend=%b, exp cw=%b split=%b div=%0d pend=%b",
             e.tag, cw, sp, dv, pd, e.cw, e.sp, e.dv, e.pd);
    end
  endtask
  task automatic run(input string tag, input int n, input logic c,
                     input logic ecw, esp, input logic [7:0] edv, input logic epd);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, c, 16'h0, ecw, esp, edv, epd);
  endtask
  initial begin
    step("reset", 1, 0, 0, 16'h0, 0, 0, 8'd0, 0);
    step("reset", 1, 0, 0, 16'h0, 0, 0, 8'd0, 0);
    run("idle", 50, 0, 0, 0, 8'd0, 0);
    step("wr8003", 0, 1, 1, 16'h8003, 0, 0, 8'd0, 1);
    step("apply3", 0, 0, 0, 16'h0, 0, 1, 8'd3, 0);
    run("first_low", 3, 0, 0, 1, 8'd3, 0);
    run("n3_high", 4, 0, 1, 1, 8'd3, 0);
    run("n3_low", 4, 0, 0, 1, 8'd3, 0);
    run("n3_high2", 1, 0, 1, 1, 8'd3, 0);
    step("wr8000_mid_high", 0, 1, 0, 16'h8000, 1, 1, 8'd3, 1);
    run("high_completes", 2, 0, 1, 1, 8'd3, 1);
    step("fall_to_switch", 0, 0, 0, 16'h0, 0, 1, 8'd3, 1);
    step("apply0", 0, 0, 0, 16'h0, 0, 1, 8'd0, 0);
    for (int i = 0; i < 3; i++) begin
      step("n0_high", 0, 0, 0, 16'h0, 1, 1, 8'd0, 0);
      step("n0_low", 0, 0, 0, 16'h0, 0, 1, 8'd0, 0);
    end
    step("wr0005_rise", 0, 1, 1, 16'h0005, 1, 1, 8'd0, 1);
    step("busy_fall", 0, 0, 1, 16'h0, 0, 1, 8'd0, 1);
    run("busy_stall", 20, 1, 0, 1, 8'd0, 1);
    step("apply_off", 0, 0, 0, 16'h0, 0, 0, 8'd5, 0);
    run("off_hold", 5, 0, 0, 0, 8'd5, 0);
    step("wr8002", 0, 1, 1, 16'h8002, 0, 0, 8'd5, 1);
    step("wr8007", 0, 1, 1, 16'h8007, 0, 0, 8'd5, 1);
    step("apply7", 0, 0, 0, 16'h0, 0, 1, 8'd7, 0);
    run("n7_first_low", 7, 0, 0, 1, 8'd7, 0);
    run("n7_high", 8, 0, 1, 1, 8'd7, 0);
    run("n7_low", 8, 0, 0, 1, 8'd7, 0);
    step("wr8001_rise", 0, 1, 1, 16'h8001, 1, 1, 8'd7, 1);
    run("n7_high_busy", 7, 1, 1, 1, 8'd7, 1);
    step("fall_switch7", 0, 0, 1, 16'h0, 0, 1, 8'd7, 1);
    step("switch_hold", 0, 0, 1, 16'h0, 0, 1, 8'd7, 1);
    step("rst_in_switch", 1, 1, 1, 16'h8003, 0, 0, 8'd0, 0);
    run("after_rst", 5, 0, 0, 0, 8'd0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
